// File: rtl/dmem_req_merger.sv
// ---------------------------------------------------------------------------
// dmem_req_merger
//
// Data-memory front end sitting between NUM_PORTS translated LSU ports and a
// dual-lane dcache. Each cycle it picks the oldest requesting port for lane 0.
// When pairing is compiled in, it may also place the next requesting port on
// lane 1. Accepted transactions are tracked in an in-order response queue of
// MAX_OUTSTANDING entries. Each dcache response is routed back to the port(s)
// that issued it. Responses belonging to transactions flushed by cancel are
// dropped.
//
// Optional feature macro: DMEM_PAIR_EN
//   defined   : a second port may ride on lane 1 when it shares the cache line,
//               the op, and cached-ness with lane 0.
//   undefined : one port per cycle, lane 1 never valid.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   cancel                 pipeline flush: kills queued entries, blocks issue
//   req/we/size/wstrb/
//   wdata/pa/uncached      per-port request fields
//   addr_ok                per-port request accepted this cycle
//   data_ok/rdata          per-port response (rdata valid with data_ok)
//   dcache_p{0,1}_valid    lane valids
//   dcache_op/tag/index    shared op and line address (taken from lane 0)
//   dcache_p{0,1}_*        per-lane offset/wstrb/wdata/size
//   dcache_uncached        lane-0 uncached attribute
//   dcache_addr_ok         dcache accepts the presented lane pair
//   dcache_data_ok/
//   dcache_p{0,1}_rdata    in-order response for the oldest accepted pair
//   busy                   response queue non-empty
// ---------------------------------------------------------------------------
module dmem_req_merger #(
    parameter int NUM_PORTS       = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = 20,
    parameter int INDEX_W         = 8,
    parameter int OFFSET_W        = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           cancel,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS-1:0]           we,
    input  logic [NUM_PORTS-1:0][1:0]      size,
    input  logic [NUM_PORTS-1:0][3:0]      wstrb,
    input  logic [NUM_PORTS-1:0][31:0]     wdata,
    input  logic [NUM_PORTS-1:0][31:0]     pa,
    input  logic [NUM_PORTS-1:0]           uncached,
    output logic [NUM_PORTS-1:0]           addr_ok,
    output logic [NUM_PORTS-1:0]           data_ok,
    output logic [NUM_PORTS-1:0][31:0]     rdata,
    output logic                           dcache_p0_valid,
    output logic                           dcache_p1_valid,
    output logic                           dcache_op,
    output logic [TAG_W-1:0]               dcache_tag,
    output logic [INDEX_W-1:0]             dcache_index,
    output logic [OFFSET_W-1:0]            dcache_p0_offset,
    output logic [3:0]                     dcache_p0_wstrb,
    output logic [31:0]                    dcache_p0_wdata,
    output logic [1:0]                     dcache_p0_size,
    output logic [OFFSET_W-1:0]            dcache_p1_offset,
    output logic [3:0]                     dcache_p1_wstrb,
    output logic [31:0]                    dcache_p1_wdata,
    output logic [1:0]                     dcache_p1_size,
    output logic                           dcache_uncached,
    input  logic                           dcache_addr_ok,
    input  logic                           dcache_data_ok,
    input  logic [31:0]                    dcache_p0_rdata,
    input  logic [31:0]                    dcache_p1_rdata,
    output logic                           busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [PW-1:0] p0_port;
        logic          p1_vld;
        logic [PW-1:0] p1_port;
    } ent_t;

    // -----------------------------------------------------------------------
    // Lane selection
    // -----------------------------------------------------------------------
    logic [PW-1:0] p0_sel, p1_sel;
    logic          has_req, pair_ok;

    // Lowest-index requester is the oldest and always owns lane 0.
    always_comb begin
        p0_sel  = '0;
        has_req = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[k]) begin
                p0_sel  = PW'(k);
                has_req = 1'b1;
            end
        end
    end

`ifdef DMEM_PAIR_EN
    logic [PW-1:0] nxt_sel;
    logic          nxt_vld;

    // Only the very next requester may pair. Skipping over it to a later
    // port would let a younger access overtake an older one.
    always_comb begin
        nxt_sel = p0_sel;
        nxt_vld = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[k] && (PW'(k) > p0_sel)) begin
                nxt_sel = PW'(k);
                nxt_vld = 1'b1;
            end
        end
    end

    assign pair_ok = nxt_vld && !uncached[p0_sel] && !uncached[nxt_sel] &&
                     (we[p0_sel] == we[nxt_sel]) &&
                     (pa[p0_sel][31:OFFSET_W] == pa[nxt_sel][31:OFFSET_W]);
    assign p1_sel  = pair_ok ? nxt_sel : p0_sel;
`else
    assign pair_ok = 1'b0;
    assign p1_sel  = p0_sel;
`endif

    // -----------------------------------------------------------------------
    // Queue state
    // -----------------------------------------------------------------------
    ent_t                 ent_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] vld_q, vld_d, kill_q, kill_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full, issue, accept, push, pop;
    ent_t                 push_ent, head;
    logic                 head_kill;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + AW'(1);
    endfunction

    // Full deliberately ignores a same-cycle pop, so a full queue always
    // blocks issue and the dcache never sees a request it could not track.
    assign full   = (count_q == CW'(MAX_OUTSTANDING));
    assign issue  = has_req && !full && !cancel;
    assign accept = issue && dcache_addr_ok;
    assign push   = accept;
    assign pop    = dcache_data_ok && (count_q != '0);
    assign busy   = (count_q != '0);

    assign push_ent.p0_port = p0_sel;
    assign push_ent.p1_vld  = pair_ok;
    assign push_ent.p1_port = p1_sel;

    assign head      = ent_q[rd_ptr_q];
    assign head_kill = kill_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            vld_d[k]  = vld_q[k];
            // Cancel kills everything in flight, including the head popping now.
            kill_d[k] = kill_q[k] | (cancel & vld_q[k]);
            if (pop && (rd_ptr_q == AW'(k)))
                vld_d[k] = 1'b0;
            if (push && (wr_ptr_q == AW'(k))) begin
                vld_d[k]  = 1'b1;
                kill_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            kill_q   <= '0;
            for (int k = 0; k < MAX_OUTSTANDING; k++)
                ent_q[k] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            kill_q   <= kill_d;
            if (push)
                ent_q[wr_ptr_q] <= push_ent;
        end
    end

    // -----------------------------------------------------------------------
    // dcache request side
    // -----------------------------------------------------------------------
    always_comb begin
        dcache_p0_valid  = issue;
        dcache_p1_valid  = issue && pair_ok;
        dcache_op        = 1'b0;
        dcache_tag       = '0;
        dcache_index     = '0;
        dcache_p0_offset = '0;
        dcache_p0_wstrb  = '0;
        dcache_p0_wdata  = '0;
        dcache_p0_size   = '0;
        dcache_p1_offset = '0;
        dcache_p1_wstrb  = '0;
        dcache_p1_wdata  = '0;
        dcache_p1_size   = '0;
        dcache_uncached  = 1'b0;
        // Fields are zeroed when nothing is requested so an idle bus is quiet.
        if (has_req) begin
            dcache_op        = we[p0_sel];
            dcache_tag       = pa[p0_sel][31 -: TAG_W];
            dcache_index     = pa[p0_sel][OFFSET_W +: INDEX_W];
            dcache_p0_offset = pa[p0_sel][OFFSET_W-1:0];
            dcache_p0_wstrb  = wstrb[p0_sel];
            dcache_p0_wdata  = wdata[p0_sel];
            dcache_p0_size   = size[p0_sel];
            dcache_p1_offset = pa[p1_sel][OFFSET_W-1:0];
            dcache_p1_wstrb  = wstrb[p1_sel];
            dcache_p1_wdata  = wdata[p1_sel];
            dcache_p1_size   = size[p1_sel];
            dcache_uncached  = uncached[p0_sel];
        end
    end

    always_comb begin
        addr_ok = '0;
        if (accept) begin
            addr_ok[p0_sel] = 1'b1;
            if (pair_ok)
                addr_ok[p1_sel] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Response routing
    // -----------------------------------------------------------------------
    always_comb begin
        data_ok = '0;
        rdata   = '0;
        if (pop && !head_kill && !cancel) begin
            data_ok[head.p0_port] = 1'b1;
            rdata[head.p0_port]   = dcache_p0_rdata;
            if (head.p1_vld) begin
                data_ok[head.p1_port] = 1'b1;
                rdata[head.p1_port]   = dcache_p1_rdata;
            end
        end
    end

endmodule
